// File: rtl/signed_seg_display.sv
// signed_seg_display
//   Captures a signed 8-bit result on a load strobe, converts its magnitude to
//   BCD with a sequential shift-add-3 (double-dabble) FSM, and drives a 4-digit
//   time-multiplexed common-anode seven-segment display as sign + 3 digits.
//   Build option: define ONES_COMP_EN to interpret value as ones' complement
//   (default is two's complement).
module signed_seg_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] MINUS = 7'b0111111;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    // Conversion state
    state_t      state;
    logic [2:0]  step;
    logic        sign_r;
    logic [7:0]  mag_r;
    logic [11:0] bcd_r;

    // Display registers, written only when a conversion completes
    logic        disp_valid;
    logic        disp_sign;
    logic [3:0]  disp_hund;
    logic [3:0]  disp_tens;
    logic [3:0]  disp_ones;

    // Scan state
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [1:0]       idx_next;
    logic             wrap;

    logic [7:0]  mag_in;
    logic [11:0] bcd_adj;
    logic [11:0] bcd_next;
    logic [7:0]  mag_next;
    logic [6:0]  seg_next;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = BLANK;
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        add3 = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Magnitude of the incoming operand
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
        mag_in = value;
`ifdef ONES_COMP_EN
        if (value[7]) begin
            mag_in = ~value;
        end
`else
        // Negation modulo 256 yields 128 for -128, matching a 9-bit negate.
        if (value[7]) begin
            mag_in = 8'd0 - value;
        end
`endif
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, mag} left
    always_comb begin
        bcd_adj = {add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};
        {bcd_next, mag_next} = {bcd_adj, mag_r} << 1;
    end

    // Conversion FSM; commits the result to the display registers on the 8th step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            step       <= 3'd0;
            sign_r     <= 1'b0;
            mag_r      <= 8'd0;
            bcd_r      <= 12'd0;
            busy       <= 1'b0;
            disp_valid <= 1'b0;
            disp_sign  <= 1'b0;
            disp_hund  <= 4'd0;
            disp_tens  <= 4'd0;
            disp_ones  <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (load) begin
                        sign_r <= value[7];
                        mag_r  <= mag_in;
                        bcd_r  <= 12'd0;
                        step   <= 3'd0;
                        busy   <= 1'b1;
                        state  <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_r <= bcd_next;
                    mag_r <= mag_next;
                    step  <= step + 3'd1;
                    if (step == 3'd7) begin
                        disp_valid <= 1'b1;
                        disp_sign  <= sign_r;
                        disp_hund  <= bcd_next[11:8];
                        disp_tens  <= bcd_next[7:4];
                        disp_ones  <= bcd_next[3:0];
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Next digit index and the glyph that digit will show
    always_comb begin
        wrap     = (cnt == CNT_LAST);
        idx_next = wrap ? idx + 2'd1 : idx;
        seg_next = BLANK;
        if (disp_valid) begin
            case (idx_next)
                2'd0: seg_next = glyph(disp_ones);
                2'd1: seg_next = (disp_hund == 4'd0 && disp_tens == 4'd0) ? BLANK : glyph(disp_tens);
                2'd2: seg_next = (disp_hund == 4'd0) ? BLANK : glyph(disp_hund);
                default: seg_next = disp_sign ? MINUS : BLANK;
            endcase
        end
    end

    // Scan counter and registered an/seg, both driven from the same next index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
            seg <= BLANK;
            an  <= 4'hF;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            idx <= idx_next;
            an  <= ~(4'b0001 << idx_next);
            seg <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_signed_seg_display.sv
// tb_signed_seg_display
//   Directed stimulus with an integer-arithmetic display model checked on every
//   cycle, plus literal digit expectations for the key values.
`timescale 1ns/1ps
module tb_signed_seg_display;

    localparam int REFRESH_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] value = 8'h00;
    logic       load = 1'b0;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int total = 0;
    int bad = 0;

    signed_seg_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .value(value),
        .load (load),
        .busy (busy),
        .seg  (seg),
        .an   (an),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] glyphs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int m_cnt = 0, m_idx = 0, m_left = 0;
    bit m_valid = 0, m_neg = 0, p_neg = 0;
    int m_mag = 0, p_mag = 0;
    logic [6:0] exp_seg = 7'h7F;
    logic [3:0] exp_an = 4'hF;
    logic       exp_busy = 1'b0;

    function automatic logic [6:0] model_digit(input int i);
        int h, t, o;
        if (!m_valid) return 7'h7F;
        h = m_mag / 100;
        t = (m_mag / 10) % 10;
        o = m_mag % 10;
        case (i)
            0: return glyphs[o];
            1: return (h == 0 && t == 0) ? 7'h7F : glyphs[t];
            2: return (h == 0) ? 7'h7F : glyphs[h];
            default: return m_neg ? 7'b0111111 : 7'h7F;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_left = 0;
            m_valid = 0; m_neg = 0; m_mag = 0;
            exp_seg = 7'h7F; exp_an = 4'hF; exp_busy = 1'b0;
        end else begin
            if (m_cnt == REFRESH_DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
            exp_an  = ~(4'b0001 << m_idx);
            exp_seg = model_digit(m_idx);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1; m_neg = p_neg; m_mag = p_mag;
                end
            end else if (load) begin
`ifdef ONES_COMP_EN
                p_neg = value[7];
                p_mag = value[7] ? int'(~value) : int'(value);
`else
                p_neg = value[7];
                p_mag = value[7] ? -int'($signed(value)) : int'(value);
`endif
                m_left = 8;
            end
            exp_busy = (m_left > 0);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("seg", {1'b0, seg}, {1'b0, exp_seg});
        check("an", {4'h0, an}, {4'h0, exp_an});
        check("dp", {7'h0, dp}, 8'h01);
        check("busy", {7'h0, busy}, {7'h0, exp_busy});
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_load(input logic [7:0] v);
        @(negedge clk); #1;
        value = v; load = 1'b1;
        @(negedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_timeout", 8'h01, 8'h00);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_digit(input string name, input int i, input logic [6:0] exp);
        int n = 0;
        logic [3:0] want;
        want = ~(4'b0001 << i);
        @(negedge clk);
        while (an !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_an"}, {4'h0, an}, {4'h0, want});
        check(name, {1'b0, seg}, {1'b0, exp});
    endtask

    task automatic show4(input string name, input logic [6:0] g3, input logic [6:0] g2,
                         input logic [6:0] g1, input logic [6:0] g0);
        check_digit({name, "_d0"}, 0, g0);
        check_digit({name, "_d1"}, 1, g1);
        check_digit({name, "_d2"}, 2, g2);
        check_digit({name, "_d3"}, 3, g3);
    endtask

    task automatic reset_now(input string name);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check({name, "_seg"}, {1'b0, seg}, 8'h7F);
        check({name, "_an"}, {4'h0, an}, 8'h0F);
        check({name, "_dp"}, {7'h0, dp}, 8'h01);
        check({name, "_busy"}, {7'h0, busy}, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) n++;
            @(negedge clk);
        end
        check(name, 8'(n), 8'd8);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (7) @(negedge clk);

        // 1. reset mid-scan, effect visible without a clock edge
        reset_now("rst_mid");
        show4("blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        // 2. +127, with busy width measured directly
        @(negedge clk); #1;
        value = 8'h7F; load = 1'b1;
        @(negedge clk); #1;
        load = 1'b0;
        count_busy("busy_len");
        wait_idle();
        show4("v127", 7'h7F, 7'b1111001, 7'b0100100, 7'b1111000);

        // 3. -128
        do_load(8'h80);
        wait_idle();
        show4("vm128", 7'b0111111, 7'b1111001, 7'b0100100, 7'b0000000);

        // 4. 8'hFF
        do_load(8'hFF);
        wait_idle();
`ifdef ONES_COMP_EN
        show4("vFF", 7'b0111111, 7'h7F, 7'h7F, 7'b1000000);
`else
        show4("vFF", 7'b0111111, 7'h7F, 7'h7F, 7'b1111001);
`endif

        // 5. second load while busy is ignored
        do_load(8'h05);
        #1;
        value = 8'h7F; load = 1'b1;
        @(negedge clk); #1;
        load = 1'b0;
        wait_idle();
        show4("v5", 7'h7F, 7'h7F, 7'h7F, 7'b0010010);

        // zero shows only the ones digit
        do_load(8'h00);
        wait_idle();
        show4("v0", 7'h7F, 7'h7F, 7'h7F, 7'b1000000);

        // 6. reset aborts a conversion at busy cycle 4
        do_load(8'h64);
        repeat (3) @(negedge clk);
        check("busy_c4", {7'h0, busy}, 8'h01);
        reset_now("rst_conv");
        show4("abort", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        do_load(8'h0A);
        wait_idle();
        show4("v10", 7'h7F, 7'h7F, 7'b1111001, 7'b1000000);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
